// File: rtl/packet_pkg.sv
// Shared packet and egress-stage constants for the 4-port switch.
package packet_pkg;

  localparam int PACKET_WIDTH   = 8;
  localparam int EGRESS_DEPTH   = 8;
  localparam int STAT_CNT_WIDTH = 16;
  localparam int EGRESS_HI_WM   = 6;

  typedef logic [PACKET_WIDTH-1:0] packet_t;

endpackage

// File: rtl/egress_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module egress_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage array; cleared on reset so the read port never shows X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/egress_buffer.sv
// Per-port egress FIFO: captures the unthrottled switch output and re-presents
// it over valid/ready, with saturating receive and drop statistics.
module egress_buffer
  import packet_pkg::*;
#(
  parameter int DEPTH     = EGRESS_DEPTH,
  parameter int CNT_WIDTH = STAT_CNT_WIDTH,
  parameter int HI_WM     = EGRESS_HI_WM
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [PACKET_WIDTH-1:0]   data_in,
  input  logic                      flush,
  output logic                      m_valid,
  output logic [PACKET_WIDTH-1:0]   m_data,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      almost_full,
  output logic [CNT_WIDTH-1:0]      rx_count,
  output logic [CNT_WIDTH-1:0]      drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [AW-1:0]        PTR_ONE   = AW'(1);
  localparam logic [LW-1:0]        LVL_ONE   = LW'(1);
  localparam logic [LW-1:0]        LVL_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0]        LVL_HI    = LW'(HI_WM);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 full_q, full_d;
  logic                 almost_full_q, almost_full_d;
  logic                 m_valid_q, m_valid_d;
  logic [CNT_WIDTH-1:0] rx_q, rx_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic                 wr_en_s, rd_en_s, drop_s;

  // Handshake decode and next-state for pointers, level, flags and counters.
  // Full is taken from the registered level, so a same-cycle read never frees room for a write.
  always_comb begin
    wr_en_s  = valid_in && !full_q && !flush;
    drop_s   = valid_in && (full_q || flush);
    rd_en_s  = m_valid_q && m_ready && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rx_d     = rx_q;
    drop_d   = drop_q;

    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {LW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end

    if (wr_en_s && (rx_q != CNT_MAX)) begin
      rx_d = rx_q + CNT_ONE;
    end else begin
      rx_d = rx_q;
    end
    if (drop_s && (drop_q != CNT_MAX)) begin
      drop_d = drop_q + CNT_ONE;
    end else begin
      drop_d = drop_q;
    end

    full_d        = (level_d == LVL_DEPTH);
    almost_full_d = (level_d >= LVL_HI);
    m_valid_d     = (level_d != {LW{1'b0}});
  end

  // State registers; flags are registered alongside the level they derive from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      level_q       <= {LW{1'b0}};
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      m_valid_q     <= 1'b0;
      rx_q          <= {CNT_WIDTH{1'b0}};
      drop_q        <= {CNT_WIDTH{1'b0}};
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      m_valid_q     <= m_valid_d;
      rx_q          <= rx_d;
      drop_q        <= drop_d;
    end
  end

  egress_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (PACKET_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en_s),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (m_data)
  );

  assign m_valid     = m_valid_q;
  assign level       = level_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign rx_count    = rx_q;
  assign drop_count  = drop_q;

endmodule
